// File: rtl/maze_episode_controller.sv
// Grid-maze environment and episode sequencer: one action in, one registered step result out.
// Optional MAZE_AUTO_RESTART_EN: pulse goal/error for one cycle in TERM, then restart without start.
module maze_episode_controller #(
  parameter int GRID_W      = 6,
  parameter int GRID_H      = 6,
  parameter int STATE_W     = 6,
  parameter int START_STATE = 0,
  parameter int GOAL_STATE  = 25,
  parameter logic [GRID_W*GRID_H-1:0] PIT_MASK = 36'h0004A6098,
  parameter int MAX_STEPS   = 64,
  parameter int STEP_CNT_W  = 7,
  parameter int EP_CNT_W    = 16,
  parameter int REWARD_W    = 16,
  parameter int REWARD_GOAL = 100,
  parameter int REWARD_PIT  = -100,
  parameter int REWARD_STEP = -1,
  parameter int REWARD_WALL = -5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       start,
  input  logic                       action_valid,
  output logic                       action_ready,
  input  logic [1:0]                 action,
  output logic                       step_valid,
  input  logic                       step_ready,
  output logic [STATE_W-1:0]         next_state,
  output logic signed [REWARD_W-1:0] reward,
  output logic                       done,
  output logic [1:0]                 done_cause,
  output logic [STATE_W-1:0]         curr_state,
  output logic [STEP_CNT_W-1:0]      step_count,
  output logic [EP_CNT_W-1:0]        episode_count,
  output logic                       goal,
  output logic                       error
);

  localparam int PIT_W = 2**STATE_W;
  localparam logic [PIT_W-1:0]            PIT_VEC   = PIT_W'(PIT_MASK);
  localparam logic [STATE_W-1:0]          START_S   = STATE_W'(START_STATE);
  localparam logic [STATE_W-1:0]          START_ROW = STATE_W'(START_STATE / GRID_W);
  localparam logic [STATE_W-1:0]          START_COL = STATE_W'(START_STATE % GRID_W);
  localparam logic [STATE_W-1:0]          GOAL_S    = STATE_W'(GOAL_STATE);
  localparam logic [STATE_W-1:0]          LAST_ROW  = STATE_W'(GRID_H - 1);
  localparam logic [STATE_W-1:0]          LAST_COL  = STATE_W'(GRID_W - 1);
  localparam logic [STATE_W-1:0]          ONE_RC    = STATE_W'(1);
  localparam logic [STEP_CNT_W-1:0]       MAX_C     = STEP_CNT_W'(MAX_STEPS);
  localparam logic [STEP_CNT_W-1:0]       ONE_STEP  = STEP_CNT_W'(1);
  localparam logic [EP_CNT_W-1:0]         ONE_EP    = EP_CNT_W'(1);
  localparam logic signed [REWARD_W-1:0]  RW_GOAL   = REWARD_W'(REWARD_GOAL);
  localparam logic signed [REWARD_W-1:0]  RW_PIT    = REWARD_W'(REWARD_PIT);
  localparam logic signed [REWARD_W-1:0]  RW_STEP   = REWARD_W'(REWARD_STEP);
  localparam logic signed [REWARD_W-1:0]  RW_WALL   = REWARD_W'(REWARD_WALL);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACT, S_RESP, S_TERM} state_t;

  state_t                       r_state, w_state_nxt;
  logic                         w_accept, w_commit, w_restart;
  logic [STATE_W-1:0]           r_row, r_col, r_nrow, r_ncol, r_curr_state, r_next_state;
  logic [STEP_CNT_W-1:0]        r_step_count;
  logic [EP_CNT_W-1:0]          r_ep_count;
  logic signed [REWARD_W-1:0]   r_reward;
  logic [1:0]                   r_cause;
  logic                         r_done, r_goal, r_error;
  logic                         w_wall;
  logic [STATE_W-1:0]           w_cand_row, w_cand_col, w_cand_state;
  logic signed [REWARD_W-1:0]   w_reward;
  logic [1:0]                   w_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_restart   = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: if (start) begin
          w_restart   = 1'b1;
          w_state_nxt = S_WAIT_ACT;
        end
        S_WAIT_ACT: if (action_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RESP;
        end
        S_RESP: if (step_ready) begin
          w_commit    = 1'b1;
          w_state_nxt = r_done ? S_TERM : S_WAIT_ACT;
        end
        S_TERM: begin
`ifdef MAZE_AUTO_RESTART_EN
          w_restart   = 1'b1;
          w_state_nxt = S_WAIT_ACT;
`else
          if (start) begin
            w_restart   = 1'b1;
            w_state_nxt = S_WAIT_ACT;
          end
`endif
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Candidate move; a wall bump leaves row/col where they are.
  always_comb begin
    w_cand_row = r_row;
    w_cand_col = r_col;
    w_wall     = 1'b0;
    case (action)
      2'd0: if (r_row == '0)      w_wall = 1'b1; else w_cand_row = r_row - ONE_RC;
      2'd1: if (r_row == LAST_ROW) w_wall = 1'b1; else w_cand_row = r_row + ONE_RC;
      2'd2: if (r_col == '0)      w_wall = 1'b1; else w_cand_col = r_col - ONE_RC;
      default: if (r_col == LAST_COL) w_wall = 1'b1; else w_cand_col = r_col + ONE_RC;
    endcase
    w_cand_state = STATE_W'(int'(w_cand_row) * GRID_W + int'(w_cand_col));
  end

  always_comb begin
    w_reward = w_wall ? RW_WALL : RW_STEP;
    w_cause  = 2'd0;
    if (w_cand_state == GOAL_S) begin
      w_reward = RW_GOAL;
      w_cause  = 2'd1;
    end else if (PIT_VEC[w_cand_state]) begin
      w_reward = RW_PIT;
      w_cause  = 2'd2;
    end else if ((r_step_count + ONE_STEP) == MAX_C) begin
      w_cause  = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row        <= START_ROW;
      r_col        <= START_COL;
      r_nrow       <= '0;
      r_ncol       <= '0;
      r_curr_state <= START_S;
      r_next_state <= '0;
      r_step_count <= '0;
      r_ep_count   <= '0;
      r_reward     <= '0;
      r_cause      <= 2'd0;
      r_done       <= 1'b0;
      r_goal       <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_restart) begin
      r_row        <= START_ROW;
      r_col        <= START_COL;
      r_curr_state <= START_S;
      r_step_count <= '0;
      r_cause      <= 2'd0;
      r_done       <= 1'b0;
      r_goal       <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_accept) begin
      r_nrow       <= w_cand_row;
      r_ncol       <= w_cand_col;
      r_next_state <= w_cand_state;
      r_reward     <= w_reward;
      r_cause      <= w_cause;
      r_done       <= (w_cause != 2'd0);
    end else if (w_commit) begin
      r_row        <= r_nrow;
      r_col        <= r_ncol;
      r_curr_state <= r_next_state;
      r_step_count <= r_step_count + ONE_STEP;
      if (r_done) begin
        r_ep_count <= r_ep_count + ONE_EP;
        r_goal     <= (r_cause == 2'd1);
        r_error    <= (r_cause == 2'd2);
      end
    end
  end

  assign action_ready  = en && (r_state == S_WAIT_ACT);
  assign step_valid    = (r_state == S_RESP);
  assign next_state    = r_next_state;
  assign reward        = r_reward;
  assign done          = r_done;
  assign done_cause    = r_cause;
  assign curr_state    = r_curr_state;
  assign step_count    = r_step_count;
  assign episode_count = r_ep_count;
  assign goal          = r_goal;
  assign error         = r_error;

endmodule

// File: tb/tb_maze_episode_controller.sv
// Scoreboard bench for maze_episode_controller: driver queues expected step results,
// a negedge monitor pops and compares them at each step handshake.
module tb_maze_episode_controller;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b1;
  logic               start = 1'b0;
  logic               action_valid = 1'b0;
  logic               action_ready;
  logic [1:0]         action = 2'd0;
  logic               step_valid;
  logic               step_ready = 1'b1;
  logic [5:0]         next_state;
  logic signed [15:0] reward;
  logic               done;
  logic [1:0]         done_cause;
  logic [5:0]         curr_state;
  logic [6:0]         step_count;
  logic [15:0]        episode_count;
  logic               goal;
  logic               error;

  maze_episode_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start),
    .action_valid(action_valid), .action_ready(action_ready), .action(action),
    .step_valid(step_valid), .step_ready(step_ready),
    .next_state(next_state), .reward(reward), .done(done), .done_cause(done_cause),
    .curr_state(curr_state), .step_count(step_count), .episode_count(episode_count),
    .goal(goal), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {int ns; int rw; int dn; int cs;} exp_t;
  exp_t sb_q[$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && en && step_valid && step_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("next_state", int'(next_state), e.ns);
        chk("reward", int'(reward), e.rw);
        chk("done", int'(done), e.dn);
        chk("done_cause", int'(done_cause), e.cs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] a, input int ns, input int rw, input int dn, input int cs);
    int n = 0;
    while (!action_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_action_ready_timeout", 0, 1);
    sb_q.push_back('{ns, rw, dn, cs});
    action = a;
    action_valid = 1'b1;
    tick();
    action_valid = 1'b0;
  endtask

  task automatic wait_resp_done();
    int n = 0;
    while (step_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_step_done_timeout", 0, 1);
  endtask

  task automatic step(input logic [1:0] a, input int ns, input int rw, input int dn, input int cs);
    send(a, ns, rw, dn, cs);
    wait_resp_done();
  endtask

  initial begin
    #12;
    chk("rst_curr_state", int'(curr_state), 0);
    chk("rst_step_count", int'(step_count), 0);
    chk("rst_episode_count", int'(episode_count), 0);
    chk("rst_reward", int'(reward), 0);
    chk("rst_next_state", int'(next_state), 0);
    chk("rst_done_cause", int'(done_cause), 0);
    chk("rst_flags", int'({action_ready, step_valid, done, goal, error}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_action_ready", int'(action_ready), 0);

    // Episode 1: right x3 into pit at 3
    pulse_start();
    chk("ep1_ready", int'(action_ready), 1);
    step(2'd3, 1, -1, 0, 0);
    step(2'd3, 2, -1, 0, 0);
    step(2'd3, 3, -100, 1, 2);
    chk("ep1_error", int'(error), 1);
    chk("ep1_goal", int'(goal), 0);
    chk("ep1_episodes", int'(episode_count), 1);
    chk("ep1_curr_state", int'(curr_state), 3);
    chk("ep1_term_ready", int'(action_ready), 0);

    // Episode 2: down x4, right to the goal
    pulse_start();
    chk("ep2_restart_state", int'(curr_state), 0);
    chk("ep2_error_cleared", int'(error), 0);
    step(2'd1, 6, -1, 0, 0);
    step(2'd1, 12, -1, 0, 0);
    step(2'd1, 18, -1, 0, 0);
    step(2'd1, 24, -1, 0, 0);
    step(2'd3, 25, 100, 1, 1);
    chk("ep2_goal", int'(goal), 1);
    chk("ep2_error", int'(error), 0);
    chk("ep2_step_count", int'(step_count), 5);
    chk("ep2_episodes", int'(episode_count), 2);

    // Episode 3: wall bump up, then left until timeout at step 64
    pulse_start();
    step(2'd0, 0, -5, 0, 0);
    pulse_start();
    chk("ep3_start_ignored", int'(step_count), 1);
    for (int i = 2; i <= 63; i++) step(2'd2, 0, -5, 0, 0);
    chk("ep3_step63", int'(step_count), 63);
    step(2'd2, 0, -5, 1, 3);
    chk("ep3_step_count", int'(step_count), 64);
    chk("ep3_cause", int'(done_cause), 3);
    chk("ep3_episodes", int'(episode_count), 3);
    chk("ep3_flags", int'({goal, error}), 0);

    // Episode 4: stall in RESP, then freeze with en low
    pulse_start();
    step_ready = 1'b0;
    send(2'd3, 1, -1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      action_valid = ~action_valid;
      action = 2'd1;
      tick();
      chk("stall_valid", int'(step_valid), 1);
      chk("stall_ready", int'(action_ready), 0);
      chk("stall_next_state", int'(next_state), 1);
      chk("stall_reward", int'(reward), -1);
    end
    action_valid = 1'b0;
    en = 1'b0;
    step_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_low_valid", int'(step_valid), 1);
      chk("en_low_step_count", int'(step_count), 0);
      chk("en_low_curr_state", int'(curr_state), 0);
    end
    en = 1'b1;
    wait_resp_done();
    chk("stall_commit_count", int'(step_count), 1);
    chk("stall_commit_state", int'(curr_state), 1);
    en = 1'b0;
    #1;
    chk("en_low_action_ready", int'(action_ready), 0);
    tick();
    en = 1'b1;

    // Reset during RESP of step 3
    step(2'd3, 2, -1, 0, 0);
    step_ready = 1'b0;
    send(2'd3, 3, -100, 1, 2);
    chk("pre_rst_valid", int'(step_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_step_valid", int'(step_valid), 0);
    chk("mid_rst_curr_state", int'(curr_state), 0);
    chk("mid_rst_step_count", int'(step_count), 0);
    chk("mid_rst_episodes", int'(episode_count), 0);
    chk("mid_rst_outputs", int'({next_state, done_cause, done}), 0);
    chk("mid_rst_reward", int'(reward), 0);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    step_ready = 1'b1;
    tick();
    pulse_start();
    chk("post_rst_state", int'(curr_state), 0);
    chk("post_rst_episodes", int'(episode_count), 0);
    step(2'd3, 1, -1, 0, 0);
    chk("post_rst_step_count", int'(step_count), 1);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
